// File: rtl/cond_logic.sv
// rtl/cond_logic.sv - ARM condition evaluation, flag register and write-strobe gating
module cond_logic #(
    parameter logic NEVER_CODE_EXEC = 1'b0
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] Cond,
    input  logic [3:0] ALUFlags,
    input  logic [1:0] FlagW,
    input  logic       PCS,
    input  logic       RegW,
    input  logic       MemW,
    input  logic       NoWrite,
    output logic       PCSrc,
    output logic       RegWrite,
    output logic       MemWrite,
    output logic       CondEx,
    output logic       CondExDelayed,
    output logic [3:0] Flags
);

    logic [3:0] flags_q, flags_d;
    logic       cond_ex_delayed_q, cond_ex_delayed_d;
    logic       cond_ex;
    logic       n_f, z_f, c_f, v_f;

    assign {n_f, z_f, c_f, v_f} = flags_q;

    // Decode the condition field against the stored (not incoming) flags
    always_comb begin
        cond_ex = 1'b0;
        unique case (Cond)
            4'b0000: cond_ex = z_f;
            4'b0001: cond_ex = ~z_f;
            4'b0010: cond_ex = c_f;
            4'b0011: cond_ex = ~c_f;
            4'b0100: cond_ex = n_f;
            4'b0101: cond_ex = ~n_f;
            4'b0110: cond_ex = v_f;
            4'b0111: cond_ex = ~v_f;
            4'b1000: cond_ex = c_f & ~z_f;
            4'b1001: cond_ex = ~(c_f & ~z_f);
            4'b1010: cond_ex = (n_f == v_f);
            4'b1011: cond_ex = (n_f != v_f);
            4'b1100: cond_ex = ~z_f & (n_f == v_f);
            4'b1101: cond_ex = z_f | (n_f != v_f);
            4'b1110: cond_ex = 1'b1;
            default: cond_ex = NEVER_CODE_EXEC;
        endcase
    end

    // Next-state: each flag half is written only when requested and the condition holds
    always_comb begin
        flags_d           = flags_q;
        cond_ex_delayed_d = cond_ex;
        if (FlagW[1] && cond_ex) flags_d[3:2] = ALUFlags[3:2];
        if (FlagW[0] && cond_ex) flags_d[1:0] = ALUFlags[1:0];
    end

    // Flag register and delayed condition, cleared asynchronously
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            flags_q           <= 4'b0000;
            cond_ex_delayed_q <= 1'b0;
        end else begin
            flags_q           <= flags_d;
            cond_ex_delayed_q <= cond_ex_delayed_d;
        end
    end

    assign CondEx        = cond_ex;
    assign CondExDelayed = cond_ex_delayed_q;
    assign Flags         = flags_q;
    assign PCSrc         = PCS & cond_ex;
    assign RegWrite      = RegW & cond_ex & ~NoWrite;
    assign MemWrite      = MemW & cond_ex;

endmodule

// File: tb/tb_cond_logic.sv
// tb/tb_cond_logic.sv - directed self-checking bench for cond_logic
module tb_cond_logic;

    localparam logic NEVER = 1'b0;

    logic       clk;
    logic       reset;
    logic [3:0] Cond;
    logic [3:0] ALUFlags;
    logic [1:0] FlagW;
    logic       PCS, RegW, MemW, NoWrite;
    logic       PCSrc, RegWrite, MemWrite, CondEx, CondExDelayed;
    logic [3:0] Flags;

    int cmp_cnt = 0;
    int err_cnt = 0;

    cond_logic #(.NEVER_CODE_EXEC(NEVER)) dut (
        .clk          (clk),
        .reset        (reset),
        .Cond         (Cond),
        .ALUFlags     (ALUFlags),
        .FlagW        (FlagW),
        .PCS          (PCS),
        .RegW         (RegW),
        .MemW         (MemW),
        .NoWrite      (NoWrite),
        .PCSrc        (PCSrc),
        .RegWrite     (RegWrite),
        .MemWrite     (MemWrite),
        .CondEx       (CondEx),
        .CondExDelayed(CondExDelayed),
        .Flags        (Flags)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference decode table written from the ARM condition definitions
    function automatic logic ref_cond(input logic [3:0] c, input logic [3:0] f);
        logic n, z, cf, v;
        {n, z, cf, v} = f;
        case (c)
            4'h0: return z;
            4'h1: return !z;
            4'h2: return cf;
            4'h3: return !cf;
            4'h4: return n;
            4'h5: return !n;
            4'h6: return v;
            4'h7: return !v;
            4'h8: return cf && !z;
            4'h9: return !cf || z;
            4'hA: return n == v;
            4'hB: return n != v;
            4'hC: return !z && (n == v);
            4'hD: return z || (n != v);
            4'hE: return 1'b1;
            default: return NEVER;
        endcase
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        Cond = 4'b1110; ALUFlags = 4'b0000; FlagW = 2'b00;
        PCS = 0; RegW = 0; MemW = 0; NoWrite = 0;
    endtask

    task automatic load_flags(input logic [3:0] f);
        Cond = 4'b1110; FlagW = 2'b11; ALUFlags = f;
        tick();
        FlagW = 2'b00;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        idle_inputs();
        tick(); tick();
        reset = 1'b0;
        tick();
        load_flags(4'b1111);
        cmp_cnt++;
        if (Flags !== 4'b1111) begin
            err_cnt++; $display("FAIL reset_preload flags=%b exp=1111", Flags);
        end
        cmp_cnt++;
        if (CondExDelayed !== 1'b1) begin
            err_cnt++; $display("FAIL reset_preload_dly got=%b exp=1", CondExDelayed);
        end
        #2 reset = 1'b1;
        #1;
        cmp_cnt++;
        if (Flags !== 4'b0000) begin
            err_cnt++; $display("FAIL async_reset_flags got=%b exp=0000", Flags);
        end
        cmp_cnt++;
        if (CondExDelayed !== 1'b0) begin
            err_cnt++; $display("FAIL async_reset_dly got=%b exp=0", CondExDelayed);
        end
        Cond = 4'b0000; #1;
        cmp_cnt++;
        if (CondEx !== 1'b0) begin
            err_cnt++; $display("FAIL reset_eq got=%b exp=0", CondEx);
        end
        Cond = 4'b0001; #1;
        cmp_cnt++;
        if (CondEx !== 1'b1) begin
            err_cnt++; $display("FAIL reset_ne got=%b exp=1", CondEx);
        end
        tick();
        cmp_cnt++;
        if (Flags !== 4'b0000) begin
            err_cnt++; $display("FAIL reset_hold got=%b exp=0000", Flags);
        end
        reset = 1'b0;
        idle_inputs();
        tick();
    endtask

    task automatic test_sub_branch();
        load_flags(4'b0110);
        cmp_cnt++;
        if (Flags !== 4'b0110) begin
            err_cnt++; $display("FAIL sub_flags got=%b exp=0110", Flags);
        end
        Cond = 4'b0000; PCS = 1; #1;
        cmp_cnt++;
        if (PCSrc !== 1'b1) begin
            err_cnt++; $display("FAIL beq_pcsrc got=%b exp=1", PCSrc);
        end
        Cond = 4'b1000; #1;
        cmp_cnt++;
        if (CondEx !== 1'b0) begin
            err_cnt++; $display("FAIL hi_condex got=%b exp=0", CondEx);
        end
        cmp_cnt++;
        if (PCSrc !== 1'b0) begin
            err_cnt++; $display("FAIL bhi_pcsrc got=%b exp=0", PCSrc);
        end
        PCS = 0;
    endtask

    task automatic test_partial_write();
        Cond = 4'b1110; FlagW = 2'b10; ALUFlags = 4'b1001;
        tick();
        cmp_cnt++;
        if (Flags !== 4'b1010) begin
            err_cnt++; $display("FAIL partial_nz got=%b exp=1010", Flags);
        end
        FlagW = 2'b01; ALUFlags = 4'b0101;
        tick();
        cmp_cnt++;
        if (Flags !== 4'b1001) begin
            err_cnt++; $display("FAIL partial_cv got=%b exp=1001", Flags);
        end
        FlagW = 2'b00;
    endtask

    task automatic test_suppressed();
        reset = 1'b1; #1; reset = 1'b0;
        Cond = 4'b0000; FlagW = 2'b11; ALUFlags = 4'b1111; RegW = 1; MemW = 1; #1;
        cmp_cnt++;
        if (RegWrite !== 1'b0 || MemWrite !== 1'b0) begin
            err_cnt++; $display("FAIL suppressed_wr got=%b%b exp=00", RegWrite, MemWrite);
        end
        tick();
        cmp_cnt++;
        if (Flags !== 4'b0000) begin
            err_cnt++; $display("FAIL suppressed_flags got=%b exp=0000", Flags);
        end
        idle_inputs();
    endtask

    task automatic test_cmp_nowrite();
        Cond = 4'b1110; RegW = 1; MemW = 1; NoWrite = 0; #1;
        cmp_cnt++;
        if (RegWrite !== 1'b1 || MemWrite !== 1'b1) begin
            err_cnt++; $display("FAIL al_writes got=%b%b exp=11", RegWrite, MemWrite);
        end
        MemW = 0; NoWrite = 1; FlagW = 2'b11; ALUFlags = 4'b1000; #1;
        cmp_cnt++;
        if (RegWrite !== 1'b0) begin
            err_cnt++; $display("FAIL cmp_regwrite got=%b exp=0", RegWrite);
        end
        tick();
        cmp_cnt++;
        if (Flags !== 4'b1000) begin
            err_cnt++; $display("FAIL cmp_flags got=%b exp=1000", Flags);
        end
        idle_inputs();
        Cond = 4'b1011; #1;
        cmp_cnt++;
        if (CondEx !== 1'b1) begin
            err_cnt++; $display("FAIL lt_condex got=%b exp=1", CondEx);
        end
        Cond = 4'b1010; #1;
        cmp_cnt++;
        if (CondEx !== 1'b0) begin
            err_cnt++; $display("FAIL ge_condex got=%b exp=0", CondEx);
        end
    endtask

    task automatic test_sweep();
        logic exp_ce;
        for (int f = 0; f < 16; f++) begin
            load_flags(f[3:0]);
            cmp_cnt++;
            if (Flags !== f[3:0]) begin
                err_cnt++; $display("FAIL sweep_load got=%b exp=%b", Flags, f[3:0]);
            end
            for (int c = 0; c < 16; c++) begin
                Cond = c[3:0]; #1;
                exp_ce = ref_cond(c[3:0], f[3:0]);
                cmp_cnt++;
                if (CondEx !== exp_ce) begin
                    err_cnt++;
                    $display("FAIL sweep_condex flags=%b cond=%b got=%b exp=%b", f[3:0], c[3:0], CondEx, exp_ce);
                end
                tick();
                cmp_cnt++;
                if (CondExDelayed !== exp_ce) begin
                    err_cnt++;
                    $display("FAIL sweep_delayed flags=%b cond=%b got=%b exp=%b", f[3:0], c[3:0], CondExDelayed, exp_ce);
                end
            end
        end
    endtask

    initial begin
        fork
            begin
                test_reset();
                test_sub_branch();
                test_partial_write();
                test_suppressed();
                test_cmp_nowrite();
                test_sweep();
            end
            begin
                #100000;
                err_cnt++;
                $display("FAIL timeout got=running exp=finished");
            end
        join_any
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_cnt, err_cnt);
        $finish;
    end

endmodule

// File: doc/cond_logic.md
Name: cond_logic

Overview:
- Consumer side of the ALU flag interface: captures the 4-bit ALUFlags {N,Z,C,V} into an architectural flag register.
- Evaluates the 4-bit ARM condition field against the stored flags.
- Gates the decoder's write strobes (PC, register file, memory) with the condition result.
- Sits between the ALU/decoder and the datapath write enables; also provides a one-cycle-delayed CondEx for multicycle control.

Parameters:
- NEVER_CODE_EXEC, 0, CondEx value produced for Cond=4'b1111 (0 = never execute, 1 = always execute).

Ports:
- clk  input  1  system clock, rising-edge.
- reset  input  1  asynchronous, active-high reset.
- Cond  input  4  instruction condition field [31:28].
- ALUFlags  input  4  {N,Z,C,V} from the ALU for the current instruction.
- FlagW  input  2  flag write request; [1] writes N,Z, [0] writes C,V.
- PCS  input  1  decoder PC-source request.
- RegW  input  1  decoder register-write request.
- MemW  input  1  decoder memory-write request.
- NoWrite  input  1  suppress register write (CMP/CMN/TST/TEQ).
- PCSrc  output  1  gated PC select.
- RegWrite  output  1  gated register-file write enable.
- MemWrite  output  1  gated memory write enable.
- CondEx  output  1  combinational condition result.
- CondExDelayed  output  1  CondEx registered one cycle.
- Flags  output  4  stored flag register {N,Z,C,V}.

Behaviour:
- Reset: asynchronous. Flags=4'b0000 and CondExDelayed=0 immediately on reset assertion, held while reset is high.
  - Combinational outputs follow from those values with the current inputs; e.g. Cond=0000 gives CondEx=0.
- CondEx is evaluated against the stored Flags, never against ALUFlags.
- Condition decode, with N,Z,C,V taken from Flags:
  - 0000 EQ: Z.
  - 0001 NE: !Z.
  - 0010 CS: C.
  - 0011 CC: !C.
  - 0100 MI: N.
  - 0101 PL: !N.
  - 0110 VS: V.
  - 0111 VC: !V.
  - 1000 HI: C&!Z.
  - 1001 LS: !(C&!Z).
  - 1010 GE: N==V.
  - 1011 LT: N!=V.
  - 1100 GT: !Z&(N==V).
  - 1101 LE: Z|(N!=V).
  - 1110 AL: 1.
  - 1111: NEVER_CODE_EXEC.
- Gating, all combinational with zero latency:
  - PCSrc = PCS & CondEx.
  - RegWrite = RegW & CondEx & !NoWrite.
  - MemWrite = MemW & CondEx.
- Flag update at the rising clk edge:
  - If FlagW[1] & CondEx: Flags[3:2] <= ALUFlags[3:2].
  - If FlagW[0] & CondEx: Flags[1:0] <= ALUFlags[1:0].
  - Halves update independently; an unwritten half holds its value.
- Latency: new flags are visible on Flags and affect CondEx exactly one cycle after the write edge.
  - A same-cycle compare-and-branch uses the old flags (no internal bypass).
- CondExDelayed <= CondEx every cycle.
- Simultaneous events:
  - FlagW=11 with a false condition: no flag change.
  - FlagW with NoWrite: flags update, RegWrite=0.
  - Reset asserted mid-cycle overrides any pending flag write.
- No X propagation: all outputs are defined for any defined input.

Test Plan:
- Reset with Flags=1111 held, then assert reset asynchronously between edges -> Flags=0000 and CondExDelayed=0 before the next edge. Then Cond=0000 -> CondEx=0; Cond=0001 -> CondEx=1.
- SUB result flags: ALUFlags=0110, FlagW=11, Cond=1110, one clk -> Flags=0110.
  - Next cycle Cond=0000, PCS=1 -> PCSrc=1.
  - Cond=1000 -> CondEx=0.
- Partial write: Flags=0110, then ALUFlags=1001 with FlagW=10 -> Flags=1010. Then FlagW=01 with ALUFlags=0101 -> Flags=1001.
- Suppressed write: Flags=0000, Cond=0000, FlagW=11, ALUFlags=1111, RegW=1, MemW=1 -> RegWrite=0, MemWrite=0, and Flags remain 0000 after the edge.
- CMP behaviour: Cond=1110, RegW=1, NoWrite=1, FlagW=11, ALUFlags=1000 -> RegWrite=0 and Flags=1000 next cycle. Then Cond=1011 -> CondEx=1; Cond=1010 -> CondEx=0.
- Exhaustive sweep over all 16 Flags values × 16 Cond values against the decode table:
  - Cond=1111 -> CondEx equals NEVER_CODE_EXEC.
  - CondExDelayed equals the previous cycle's CondEx.
